// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/ID-stage controls, external PC+4 adder and imem, plus IF/ID outputs.
// The slave modport belongs to the fetch stage; the master modport belongs to the surrounding core.
interface if_fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      pc_plus4;
  logic [31:0]      imem_instr;
  logic [31:0]      pc;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc_plus4;
  logic             ifid_valid;
  logic             err_misaligned;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, pc_plus4, imem_instr,
    input  pc, ifid_instr, ifid_pc_plus4, ifid_valid, err_misaligned, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, pc_plus4, imem_instr,
    output pc, ifid_instr, ifid_pc_plus4, ifid_valid, err_misaligned, fetch_count
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// state | meaning
// BOOT  | one cycle after reset release, PC held while imem produces its first word
// RUN   | normal fetch: redirect > stall > sequential
// HALT  | misaligned redirect trapped; frozen until reset
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  if_fetch_stage_if.slave bus
);
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]       state;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic [31:0]      pp4_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic        redirect;
  logic [31:0] target;
  logic        misaligned;

  // Branch resolves ahead of jump when the ID stage reports both.
  always_comb begin
    redirect   = bus.branch_taken | bus.jump;
    target     = bus.branch_taken ? bus.branch_target : bus.jump_target;
    misaligned = (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pp4_q   <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (redirect) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            if (misaligned) begin
              state <= ST_HALT;
              err_q <= 1'b1;
            end else begin
              pc_q <= target;
            end
          end else if (!bus.stall) begin
            pc_q    <= bus.pc_plus4;
            instr_q <= bus.imem_instr;
            pp4_q   <= bus.pc_plus4;
            valid_q <= 1'b1;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

  assign bus.pc             = pc_q;
  assign bus.ifid_instr     = instr_q;
  assign bus.ifid_pc_plus4  = pp4_q;
  assign bus.ifid_valid     = valid_q;
  assign bus.err_misaligned = err_q;
  assign bus.fetch_count    = cnt_q;
endmodule
